// File: rtl/mmix_defs.sv
// Shared MMIX memory-interface definitions: datasize encodings, request
// bundle and the arbiter state type.
package mmix_defs;

  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_WYDE  = 2'd1;
  localparam logic [1:0] SIZE_TETRA = 2'd2;
  localparam logic [1:0] SIZE_OCTA  = 2'd3;

  typedef struct packed {
    logic [63:0] address;
    logic [1:0]  datasize;
    logic        read;
    logic        write;
    logic [63:0] writedata;
  } mem_req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_ABORT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker between the fetch and data ports; remembers
// which port won the last arbitration so a tie goes to the other one.
module rr_arb2 #(
  parameter int FETCH_FIRST = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic req_fetch,
  input  logic req_data,
  input  logic update,
  output logic pick_data
);

  logic last_data;

  // Seeding last_data as "data won last" makes the first tie go to fetch.
  always_ff @(posedge clk) begin
    if (reset)
      last_data <= (FETCH_FIRST != 0);
    else if (update)
      last_data <= pick_data;
  end

  assign pick_data = req_data & (~req_fetch | ~last_data);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one downstream memory
// port, with CSWAP lock support and flush (request drop) handling.
module mem_port_arbiter #(
  parameter int FETCH_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_address,
  input  logic        i_read,
  output logic [63:0] i_readdata,
  output logic        i_done,
  input  logic [63:0] d_address,
  input  logic [1:0]  d_datasize,
  input  logic [63:0] d_writedata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic        d_lock,
  output logic [63:0] d_readdata,
  output logic        d_done,
  output logic [63:0] mem_address,
  output logic [1:0]  mem_datasize,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_writedata,
  input  logic [63:0] mem_readdata,
  input  logic        mem_done,
  output logic        grant_d
);

  import mmix_defs::*;

  arb_state_t state, state_nx;
  logic       grant_nx;
  logic       arb_update;
  logic       pick_data;
  logic       d_req;
  logic       owner_req;
  logic       fwd_done;
  mem_req_t   req;

  assign d_req     = d_read | d_write;
  assign owner_req = grant_d ? d_req : i_read;

  rr_arb2 #(.FETCH_FIRST(FETCH_FIRST)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_fetch (i_read),
    .req_data  (d_req),
    .update    (arb_update),
    .pick_data (pick_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      grant_d <= 1'b0;
    end else begin
      state   <= state_nx;
      grant_d <= grant_nx;
    end
  end

  // A dropped owner request is a flush: the outstanding done must be swallowed.
  always_comb begin
    state_nx   = state;
    grant_nx   = grant_d;
    arb_update = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_read | d_req) begin
          state_nx   = S_BUSY;
          grant_nx   = pick_data;
          arb_update = 1'b1;
        end
      end
      S_BUSY: begin
        if (!owner_req)
          state_nx = mem_done ? S_IDLE : S_ABORT;
        else if (mem_done && !(grant_d && d_lock))
          state_nx = S_IDLE;
      end
      S_ABORT: begin
        if (mem_done)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Write wins over read when the data port raises both.
  always_comb begin
    req = '0;
    if (state == S_BUSY && owner_req) begin
      if (grant_d) begin
        req.address   = d_address;
        req.datasize  = d_datasize;
        req.read      = d_read & ~d_write;
        req.write     = d_write;
        req.writedata = d_writedata;
      end else begin
        req.address  = i_address;
        req.datasize = SIZE_OCTA;
        req.read     = i_read;
      end
    end
  end

  assign mem_address   = req.address;
  assign mem_datasize  = req.datasize;
  assign mem_read      = req.read;
  assign mem_write     = req.write;
  assign mem_writedata = req.writedata;

  assign fwd_done   = (state == S_BUSY) && owner_req && mem_done;
  assign i_done     = fwd_done & ~grant_d;
  assign d_done     = fwd_done & grant_d;
  assign i_readdata = mem_readdata;
  assign d_readdata = mem_readdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (FETCH_FIRST=1).
module tb_mem_port_arbiter;

  import mmix_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] i_address;
  logic        i_read;
  logic [63:0] i_readdata;
  logic        i_done;
  logic [63:0] d_address;
  logic [1:0]  d_datasize;
  logic [63:0] d_writedata;
  logic        d_read;
  logic        d_write;
  logic        d_lock;
  logic [63:0] d_readdata;
  logic        d_done;
  logic [63:0] mem_address;
  logic [1:0]  mem_datasize;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_writedata;
  logic [63:0] mem_readdata;
  logic        mem_done;
  logic        grant_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.FETCH_FIRST(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_address     (i_address),
    .i_read        (i_read),
    .i_readdata    (i_readdata),
    .i_done        (i_done),
    .d_address     (d_address),
    .d_datasize    (d_datasize),
    .d_writedata   (d_writedata),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_lock        (d_lock),
    .d_readdata    (d_readdata),
    .d_done        (d_done),
    .mem_address   (mem_address),
    .mem_datasize  (mem_datasize),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_done      (mem_done),
    .grant_d       (grant_d)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_address = '0; i_read = 0;
    d_address = '0; d_datasize = 0; d_writedata = '0;
    d_read = 0; d_write = 0; d_lock = 0;
    mem_readdata = '0; mem_done = 0;
    tick(); tick();
    reset = 1'b0;
    settle();
    checks++; if (mem_read !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_read got=%b exp=0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_write got=%b exp=0", mem_write); end
    checks++; if ({i_done, d_done} !== 2'b00) begin failures++; $display("[TB] FAIL reset_dones got=%b exp=00", {i_done, d_done}); end
    checks++; if (grant_d !== 1'b0) begin failures++; $display("[TB] FAIL reset_grant_d got=%b exp=0", grant_d); end
    checks++; if (mem_address !== 64'h0) begin failures++; $display("[TB] FAIL reset_mem_address got=%h exp=0", mem_address); end
  endtask

  task automatic test_fetch_only();
    tick();
    i_read = 1; i_address = 64'h100;
    settle();
    checks++; if (mem_read !== 1'b0) begin failures++; $display("[TB] FAIL fetch_c0_mem_read got=%b exp=0", mem_read); end
    tick();
    settle();
    checks++; if ({mem_read, mem_write, mem_datasize} !== 4'b1011) begin failures++; $display("[TB] FAIL fetch_c1_strobes got=%b exp=1011", {mem_read, mem_write, mem_datasize}); end
    checks++; if (mem_address !== 64'h100) begin failures++; $display("[TB] FAIL fetch_c1_address got=%h exp=100", mem_address); end
    tick();
    tick();
    mem_done = 1; mem_readdata = 64'hDEAD;
    settle();
    checks++; if ({i_done, d_done} !== 2'b10) begin failures++; $display("[TB] FAIL fetch_c3_dones got=%b exp=10", {i_done, d_done}); end
    checks++; if (i_readdata !== 64'hDEAD) begin failures++; $display("[TB] FAIL fetch_c3_readdata got=%h exp=dead", i_readdata); end
    tick();
    mem_done = 0; i_read = 0;
    settle();
    checks++; if (mem_read !== 1'b0) begin failures++; $display("[TB] FAIL fetch_c4_mem_read got=%b exp=0", mem_read); end
  endtask

  task automatic test_round_robin();
    // Fresh reset so the first tie follows FETCH_FIRST.
    reset = 1; tick(); reset = 0;
    i_read = 1; i_address = 64'h100;
    d_read = 1; d_address = 64'h200; d_datasize = SIZE_TETRA;
    tick();
    mem_done = 1; mem_readdata = 64'h11;
    settle();
    checks++; if (grant_d !== 1'b0) begin failures++; $display("[TB] FAIL tie1_grant got=%b exp=0", grant_d); end
    checks++; if ({i_done, d_done} !== 2'b10) begin failures++; $display("[TB] FAIL tie1_dones got=%b exp=10", {i_done, d_done}); end
    tick();
    mem_done = 0; i_read = 0;
    settle();
    checks++; if (mem_read !== 1'b0) begin failures++; $display("[TB] FAIL tie1_bubble got=%b exp=0", mem_read); end
    tick();
    mem_done = 1; mem_readdata = 64'h22;
    settle();
    checks++; if ({grant_d, mem_read, mem_datasize} !== 4'b1110) begin failures++; $display("[TB] FAIL tie1_data_grant got=%b exp=1110", {grant_d, mem_read, mem_datasize}); end
    checks++; if (mem_address !== 64'h200) begin failures++; $display("[TB] FAIL tie1_data_addr got=%h exp=200", mem_address); end
    checks++; if ({i_done, d_done, d_readdata} !== {2'b01, 64'h22}) begin failures++; $display("[TB] FAIL tie1_data_done got=%b/%h exp=01/22", {i_done, d_done}, d_readdata); end
    tick();
    mem_done = 0;
    i_read = 1;
    // Data was served last, so the next tie goes to fetch; then data.
    for (int k = 0; k < 2; k++) begin
      tick();
      mem_done = 1;
      settle();
      checks++; if (grant_d !== 1'(k)) begin failures++; $display("[TB] FAIL tie%0d_grant got=%b exp=%0d", k + 2, grant_d, k); end
      tick();
      mem_done = 0; i_read = 0; d_read = 0;
      tick();
      i_read = 1; d_read = 1;
    end
    i_read = 0; d_read = 0;
    tick();
  endtask

  task automatic test_cswap();
    d_read = 1; d_lock = 1; d_address = 64'h300; d_datasize = SIZE_OCTA;
    tick();
    i_read = 1; i_address = 64'h400;
    mem_done = 1; mem_readdata = 64'h77;
    settle();
    checks++; if ({grant_d, d_done, i_done} !== 3'b110) begin failures++; $display("[TB] FAIL cswap_read got=%b exp=110", {grant_d, d_done, i_done}); end
    tick();
    mem_done = 0; d_read = 0; d_write = 1; d_writedata = 64'h5; d_lock = 0;
    settle();
    checks++; if ({grant_d, mem_read, mem_write} !== 3'b101) begin failures++; $display("[TB] FAIL cswap_write_strobes got=%b exp=101", {grant_d, mem_read, mem_write}); end
    checks++; if (mem_writedata !== 64'h5) begin failures++; $display("[TB] FAIL cswap_writedata got=%h exp=5", mem_writedata); end
    tick();
    mem_done = 1;
    settle();
    checks++; if ({d_done, i_done} !== 2'b10) begin failures++; $display("[TB] FAIL cswap_write_done got=%b exp=10", {d_done, i_done}); end
    tick();
    mem_done = 0; d_write = 0;
    settle();
    checks++; if (mem_read !== 1'b0) begin failures++; $display("[TB] FAIL cswap_bubble got=%b exp=0", mem_read); end
    tick();
    mem_done = 1; mem_readdata = 64'h99;
    settle();
    checks++; if ({grant_d, mem_read, i_done} !== 3'b011 || mem_address !== 64'h400) begin failures++; $display("[TB] FAIL cswap_fetch got=%b/%h exp=011/400", {grant_d, mem_read, i_done}, mem_address); end
    tick();
    mem_done = 0; i_read = 0;
    tick();
  endtask

  task automatic test_flush();
    d_read = 1; d_address = 64'h500;
    tick();
    settle();
    checks++; if ({grant_d, mem_read} !== 2'b11) begin failures++; $display("[TB] FAIL flush_c1 got=%b exp=11", {grant_d, mem_read}); end
    tick();
    d_read = 0;
    settle();
    checks++; if ({mem_read, d_done} !== 2'b00) begin failures++; $display("[TB] FAIL flush_c2 got=%b exp=00", {mem_read, d_done}); end
    tick();
    settle();
    checks++; if ({mem_read, mem_write, d_done} !== 3'b000) begin failures++; $display("[TB] FAIL flush_c3 got=%b exp=000", {mem_read, mem_write, d_done}); end
    tick();
    mem_done = 1;
    settle();
    checks++; if ({d_done, i_done} !== 2'b00) begin failures++; $display("[TB] FAIL flush_c4_swallow got=%b exp=00", {d_done, i_done}); end
    tick();
    mem_done = 0;
    settle();
    checks++; if (dut.state !== S_IDLE) begin failures++; $display("[TB] FAIL flush_c5_state got=%0d exp=%0d", dut.state, S_IDLE); end
  endtask

  task automatic test_reset_mid_busy();
    i_read = 1; i_address = 64'h600;
    tick();
    settle();
    checks++; if (mem_read !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_busy got=%b exp=1", mem_read); end
    reset = 1; i_read = 0;
    tick();
    reset = 0; mem_done = 1;
    settle();
    checks++; if ({i_done, d_done, mem_read} !== 3'b000) begin failures++; $display("[TB] FAIL rstmid_stray_done got=%b exp=000", {i_done, d_done, mem_read}); end
    tick();
    mem_done = 0;
  endtask

  task automatic test_read_write_both();
    d_read = 1; d_write = 1; d_datasize = SIZE_WYDE; d_address = 64'h700; d_writedata = 64'hAB;
    tick();
    settle();
    checks++; if ({mem_write, mem_read, mem_datasize} !== 4'b1001) begin failures++; $display("[TB] FAIL rw_both got=%b exp=1001", {mem_write, mem_read, mem_datasize}); end
    mem_done = 1;
    settle();
    checks++; if (d_done !== 1'b1) begin failures++; $display("[TB] FAIL rw_both_done got=%b exp=1", d_done); end
    tick();
    mem_done = 0; d_read = 0; d_write = 0;
    tick();
    mem_done = 1;
    settle();
    checks++; if ({i_done, d_done, mem_read} !== 3'b000) begin failures++; $display("[TB] FAIL idle_done got=%b exp=000", {i_done, d_done, mem_read}); end
    tick();
    mem_done = 0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_round_robin();
    test_cswap();
    test_flush();
    test_reset_mid_busy();
    test_read_write_both();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter FETCH_FIRST, default 1, which selects the round-robin winner after reset: 1 = fetch port, 0 = data port.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_address  input  64  fetch request address.
REQ-005 SHALL have port i_read  input  1  fetch read request, a level held until i_done.
REQ-006 SHALL have port i_readdata / i_done  output  64/1  fetch read data and completion pulse.
REQ-007 SHALL have port d_address, d_datasize, d_writedata  input  64/2/64  data-port request fields; datasize 0=byte, 1=wyde, 2=tetra, 3=octa.
REQ-008 SHALL have port d_read, d_write  input  1/1  data-port request levels, held until d_done.
REQ-009 SHALL have port d_lock  input  1  data port keeps the grant after the current done (CSWAP read-then-write).
REQ-010 SHALL have port d_readdata / d_done  output  64/1  data-port read data and completion pulse.
REQ-011 SHALL have port mem_address, mem_datasize, mem_read, mem_write, mem_writedata  output  64/2/1/1/64  downstream memory request.
REQ-012 SHALL have port mem_readdata / mem_done  input  64/1  downstream read data and one-cycle completion.
REQ-013 SHALL have port grant_d  output  1  current owner: 0 = fetch, 1 = data; valid only while busy.

Function
REQ-014 SHALL implement FSM states S_IDLE, S_BUSY, S_ABORT.
REQ-015 In S_IDLE with any request, SHALL register grant and enter S_BUSY at the next edge; arbitration latency is exactly 1 cycle.
REQ-016 If both ports request in S_IDLE, SHALL grant the port not granted last (round-robin); the first tie after reset SHALL follow FETCH_FIRST.
REQ-017 In S_BUSY, SHALL drive the mem_* outputs combinationally from the granted port; fetch SHALL always drive mem_datasize=3 and mem_write=0.
REQ-018 In S_IDLE and S_ABORT, mem_read and mem_write SHALL be 0.
REQ-019 SHALL route mem_done/mem_readdata only to the granted port; the non-granted port's done SHALL stay 0.
REQ-020 SHALL hold i_readdata/d_readdata at mem_readdata (pass-through); the data is valid only when the matching done is asserted.
REQ-021 On mem_done in S_BUSY, SHALL return to S_IDLE, so at least one idle bubble separates transactions.
REQ-022 Exception to REQ-021: if grant is data and d_lock=1 at mem_done, SHALL stay in S_BUSY with the data grant; the next data request SHALL be driven from the next cycle with no re-arbitration.
REQ-023 If d_read and d_write are both 1, SHALL forward the write only.
REQ-024 If the granted port drops its request before mem_done (flush), SHALL enter S_ABORT, keep no strobe asserted, and wait for mem_done; that done SHALL be swallowed (not forwarded); then SHALL return to S_IDLE.
REQ-025 mem_done in S_IDLE SHALL be ignored.
REQ-026 Last-grant SHALL update only when entering S_BUSY from S_IDLE.

Reset
REQ-027 While reset=1 at an edge, SHALL set state=S_IDLE, last-grant per FETCH_FIRST, and grant_d=0.
REQ-028 Outputs after reset: mem_read=0, mem_write=0, i_done=0, d_done=0; address and data outputs are don't-care but SHALL be 0 in simulation.
REQ-029 Reset during S_BUSY or S_ABORT SHALL abandon the transaction, and a following stray mem_done SHALL be ignored.

Structure
REQ-030 The datasize encoding constants and a mem_req_t struct (address, datasize, read, write, writedata) SHALL live in the shared mmix_defs package.
REQ-031 SHALL use one sub-module, rr_arb2: a 2-way round-robin picker with a last-grant register.
REQ-032 Expected size is 150–250 RTL lines.

Verification
REQ-033 Fetch only: i_read=1, address 0x100 at cycle 0; mem_read=1 from cycle 1; mem_done at cycle 3 with readdata 0xDEAD -> i_done=1 and i_readdata=0xDEAD at cycle 3, mem_read=0 at cycle 4.
REQ-034 Simultaneous i_read and d_read after reset with FETCH_FIRST=1 -> fetch served first, data granted in the idle cycle after i_done; repeated ties alternate.
REQ-035 CSWAP: d_read with d_lock=1, done, then d_write 0x5 -> mem_write=1 in the cycle after the read done, with a pending i_read not granted until d_done of the write.
REQ-036 Flush: d_read granted, d_read dropped at cycle 2, mem_done at cycle 4 -> d_done stays 0 throughout, state S_IDLE at cycle 5.
REQ-037 Reset asserted mid-S_BUSY, then mem_done one cycle later -> no done forwarded and mem_read=0.
REQ-038 d_read=d_write=1, datasize=1 -> mem_write=1, mem_read=0, mem_datasize=1.
